// File: rtl/decode_stage_hz_pkg.sv
// decode_stage_hz_pkg: shared opcodes, ALU/immediate encodings, ID/EX control struct
package decode_stage_hz_pkg;
  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011, OP_BEQ = 7'b1100011;
  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR = 3'b011, ALU_SLT = 3'b101;
  typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} imm_src_e;
  typedef struct packed {
    logic reg_write;
    logic alu_src;
    logic mem_write;
    logic result_src;
    logic branch;
  } ctrl_t;
  function automatic int reg_aw(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/decode_stage_hz_ctrl.sv
// control_unit: main decoder plus ALU decoder for the supported opcodes
module control_unit import decode_stage_hz_pkg::*; #(
  parameter int ALUC_W = 3
) (
  input  logic [6:0]        op,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  output ctrl_t             ctrl,
  output imm_src_e          imm_src,
  output logic [ALUC_W-1:0] alu_control
);
  logic [1:0] alu_op;
  logic [2:0] alu_c;
  always_comb begin
    ctrl = '0;
    imm_src = IMM_I;
    alu_op = 2'b00;
    case (op)
      OP_LW:  ctrl = 5'b11010;
      OP_SW:  begin ctrl = 5'b01100; imm_src = IMM_S; end
      OP_R:   begin ctrl = 5'b10000; alu_op = 2'b10; end
      OP_I:   begin ctrl = 5'b11000; alu_op = 2'b10; end
      OP_BEQ: begin ctrl = 5'b00001; imm_src = IMM_B; alu_op = 2'b01; end
      default: ;
    endcase
    alu_c = alu_op == 2'b00 ? ALU_ADD :
            alu_op == 2'b01 ? ALU_SUB :
            funct3 == 3'b000 ? ((op[5] & funct7b5) ? ALU_SUB : ALU_ADD) :
            funct3 == 3'b010 ? ALU_SLT :
            funct3 == 3'b110 ? ALU_OR :
            funct3 == 3'b111 ? ALU_AND : ALU_ADD;
    alu_control = ALUC_W'(alu_c);
  end
endmodule

// File: rtl/decode_stage_hz_ext.sv
// sign_extend: builds the sign-extended I/S/B/J immediate
module sign_extend import decode_stage_hz_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instr,
  input  imm_src_e        imm_src,
  output logic [XLEN-1:0] imm_ext
);
  logic signed [31:0] v;
  always_comb begin
    v = imm_src == IMM_I ? {{20{instr[31]}}, instr[31:20]} :
        imm_src == IMM_S ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
        imm_src == IMM_B ? {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0} :
                           {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    imm_ext = XLEN'(v);
  end
endmodule

// File: rtl/decode_stage_hz_rf.sv
// rf_bypass: 2R1W register file, x0 hardwired, write-through bypass, sync clear
module rf_bypass #(
  parameter int NREG = 32,
  parameter int XLEN = 32,
  parameter int AW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);
  logic [XLEN-1:0] mem [NREG];
  always_ff @(posedge clk)
    if (rst) for (int i = 0; i < NREG; i++) mem[i] <= '0;
    else if (we && wa != '0) mem[wa] <= wd;
  always_comb begin
    rd1 = ra1 == '0 ? '0 : (we && wa == ra1) ? wd : mem[ra1];
    rd2 = ra2 == '0 ? '0 : (we && wa == ra2) ? wd : mem[ra2];
  end
endmodule

// File: rtl/decode_stage_hz.sv
// decode_stage_hz: ID decode with RF bypass, load-use stall, flush and valid/ready ID/EX register
module decode_stage_hz import decode_stage_hz_pkg::*; #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int ALUC_W = 3,
  parameter int CNT_W = 16,
  localparam int REG_AW = reg_aw(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_d,
  output logic              ready_d,
  input  logic [31:0]       InstrD,
  input  logic [XLEN-1:0]   PCD,
  input  logic [XLEN-1:0]   PCPlus4D,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] RDW,
  input  logic [XLEN-1:0]   ResultW,
  input  logic              flush,
  input  logic              ready_e,
  output logic              valid_e,
  output logic              RegWriteE,
  output logic              ALUSrcE,
  output logic              MemWriteE,
  output logic              ResultSrcE,
  output logic              BranchE,
  output logic [ALUC_W-1:0] ALUControlE,
  output logic [XLEN-1:0]   RD1_E,
  output logic [XLEN-1:0]   RD2_E,
  output logic [XLEN-1:0]   Imm_Ext_E,
  output logic [REG_AW-1:0] Rs1_E,
  output logic [REG_AW-1:0] Rs2_E,
  output logic [REG_AW-1:0] RD_E,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   PCPlus4E,
  output logic [CNT_W-1:0]  bubble_cnt
);
  typedef struct packed {
    logic              valid;
    ctrl_t             c;
    logic [ALUC_W-1:0] aluc;
    logic [XLEN-1:0]   rd1, rd2, imm, pc, pc4;
    logic [REG_AW-1:0] rs1, rs2, rd;
  } ex_t;
  ex_t ex_d, ex_q, dec, bub;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [REG_AW-1:0] rs1, rs2, rd;
  logic [XLEN-1:0] rf_rd1, rf_rd2, imm;
  logic [ALUC_W-1:0] alu_control;
  ctrl_t ctrl;
  imm_src_e imm_src;
  logic adv, hz;
  assign rs1 = InstrD[15 +: REG_AW];
  assign rs2 = InstrD[20 +: REG_AW];
  assign rd = InstrD[7 +: REG_AW];
  control_unit #(.ALUC_W(ALUC_W)) u_ctrl (
    .op(InstrD[6:0]), .funct3(InstrD[14:12]), .funct7b5(InstrD[30]),
    .ctrl(ctrl), .imm_src(imm_src), .alu_control(alu_control)
  );
  sign_extend #(.XLEN(XLEN)) u_ext (.instr(InstrD[31:7]), .imm_src(imm_src), .imm_ext(imm));
  rf_bypass #(.NREG(NREG), .XLEN(XLEN), .AW(REG_AW)) u_rf (
    .clk(clk), .rst(rst), .we(RegWriteW), .wa(RDW), .wd(ResultW),
    .ra1(rs1), .ra2(rs2), .rd1(rf_rd1), .rd2(rf_rd2)
  );
  always_comb begin
    adv = ready_e | ~ex_q.valid;
    hz = valid_d & ex_q.valid & ex_q.c.result_src & ex_q.c.reg_write & (ex_q.rd != '0) &
         (ex_q.rd == rs1 | ex_q.rd == rs2);
    ready_d = flush | (adv & ~hz);
    dec = '{valid: 1'b1, c: ctrl, aluc: alu_control, rd1: rf_rd1, rd2: rf_rd2, imm: imm,
            pc: PCD, pc4: PCPlus4D, rs1: rs1, rs2: rs2, rd: rd};
    bub = ex_q;
    bub.valid = 1'b0;
    bub.c = '0;
    bub.aluc = '0;
    ex_d = flush ? bub : !adv ? ex_q : hz ? bub : valid_d ? dec : bub;
    cnt_d = cnt_q + CNT_W'(~flush & adv & hz & ~&cnt_q);
  end
  always_ff @(posedge clk)
    if (rst) begin
      ex_q <= '0;
      cnt_q <= '0;
    end else begin
      ex_q <= ex_d;
      cnt_q <= cnt_d;
    end
  assign valid_e = ex_q.valid;
  assign RegWriteE = ex_q.c.reg_write;
  assign ALUSrcE = ex_q.c.alu_src;
  assign MemWriteE = ex_q.c.mem_write;
  assign ResultSrcE = ex_q.c.result_src;
  assign BranchE = ex_q.c.branch;
  assign ALUControlE = ex_q.aluc;
  assign RD1_E = ex_q.rd1;
  assign RD2_E = ex_q.rd2;
  assign Imm_Ext_E = ex_q.imm;
  assign Rs1_E = ex_q.rs1;
  assign Rs2_E = ex_q.rs2;
  assign RD_E = ex_q.rd;
  assign PCE = ex_q.pc;
  assign PCPlus4E = ex_q.pc4;
  assign bubble_cnt = cnt_q;
endmodule
